// File: rtl/fetch_queue_stage_if.sv
// Instruction-memory read port used by the fetch stage.
// A request transfers on any cycle where imem_req && imem_ready. imem_addr is held while imem_req is high
// and not yet accepted. imem_rvalid/imem_rdata return data for the single outstanding request and have no ready.
interface fetch_queue_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the fetch PC and keeps at most one instruction-memory read in flight.
// Returned {PC, instruction} pairs are buffered in a QDEPTH-entry FIFO that feeds the IF/ID register.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                StallF,
  input  logic                FlushF,
  input  logic [XLEN-1:0]     PCin,
  fetch_queue_stage_if.master imem,
  output logic                ValidF,
  output logic [XLEN-1:0]     InstrF,
  output logic [XLEN-1:0]     PCF,
  output logic [XLEN-1:0]     PCPlus4F
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_pend;
  logic            r_drop;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc_mem    [QDEPTH];
  logic [XLEN-1:0] r_instr_mem [QDEPTH];

  logic            w_req;
  logic            w_accept;
  logic            w_resp;
  logic            w_enq;
  logic            w_deq;
  logic            w_valid;
  logic [CW:0]     w_occupancy;

  // The in-flight request reserves a slot, so its response always finds room.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_pend};
  assign w_valid     = (r_count != '0);
  assign w_req       = reset && !FlushF && (!r_pend || imem.imem_rvalid) && (w_occupancy < LIMIT);
  assign w_accept    = w_req && imem.imem_ready;
  assign w_resp      = imem.imem_rvalid && r_pend;
  assign w_enq       = w_resp && !r_drop && !FlushF;
  assign w_deq       = w_valid && !StallF && !FlushF;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_pend     <= 1'b0;
      r_drop     <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (FlushF) begin
      // A response arriving in the flush cycle is simply not written; a later one is marked for discard.
      r_fetch_pc <= PCin;
      r_pend     <= r_pend && !imem.imem_rvalid;
      r_drop     <= r_pend && !imem.imem_rvalid;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_pend     <= 1'b1;
      end else if (w_resp) begin
        r_pend     <= 1'b0;
      end
      if (w_resp && r_drop) r_drop <= 1'b0;
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset && w_enq) begin
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
      r_instr_mem[r_wr_ptr] <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  assign ValidF   = w_valid;
  assign PCF      = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign InstrF   = w_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign PCPlus4F = PCF + XLEN'(4);

endmodule
